frame_decoder: RTL and testbench
================================

# frame_decoder

Consumes each 80-sample window from the upstream 40 kHz sampler and recovers one byte per window. It detects the sampler's end-of-window (falling `sample_flag`) and latches the window. It then majority-votes ten 8-sample bit cells, checks start bit and even parity, and presents the byte on a valid/ready handshake to the downstream consumer. Framing and overrun errors are flagged and counted.

## Interface
Parameters:
- `SAMPLES_PER_BIT`, 8: samples per bit cell.
- `NUM_CELLS`, 10: cells per window (start, 8 data, parity).
- `ERR_W`, 8: error counter width.

Ports:
- `clk`  in  1  40 kHz sampling clock, same as the sampler.
- `rst`  in  1  one clock; reset is asynchronous and active-high.
- `sample`  in  80  sampler window; bit 78 is the oldest sample, bit 0 the newest, bit 79 unused.
- `sample_flag`  in  1  high while the sampler is filling `sample`.
- `data_out`  out  8  decoded byte, MSB first on the line.
- `data_valid`  out  1  `data_out` valid; held until accepted.
- `data_ready`  in  1  consumer accepts when `data_valid & data_ready`.
- `frame_err`  out  1  1-cycle pulse: start bit 0 or parity mismatch.
- `overrun`  out  1  1-cycle pulse: a window ended while not IDLE; that window is dropped.
- `err_count`  out  ERR_W  saturating count of frame_err plus overrun events.
- `busy`  out  1  state is not IDLE.

## Operation
- Edge detect: `flag_d` registers `sample_flag`. `fall = flag_d & ~sample_flag`. `flag_d` resets to 0, so a high flag at reset release is never a fall.
- Window: at capture, `win <= sample` with bit 79 forced to 0.
- Cell k (k = 0..9) = `win[79-8k -: 8]`. Voted bit = 1 iff popcount ≥ 5. Cell 0 therefore needs 5 of its 7 real samples.
- FSM states: IDLE, DECODE, CHECK, OUTPUT.
  - IDLE: on `fall`, capture the window, set `cell_idx` = 0, go to DECODE.
  - DECODE: vote cell `cell_idx` and shift the result into a 10-bit `bits` register (cell 0 ends in the MSB). Increment `cell_idx`. After cell 9, go to CHECK.
  - CHECK: `ok = bits[9] == 1 && ^bits[8:0] == 0` (even parity over data and parity bit).
    - If ok: `data_out <= bits[8:1]`, `data_valid <= 1`, go to OUTPUT.
    - If not ok: pulse `frame_err`, increment `err_count`, go to IDLE. `data_out` is unchanged.
  - OUTPUT: hold `data_out` and `data_valid`. On `data_ready`, clear `data_valid` and go to IDLE.
- `fall` in any non-IDLE state: pulse `overrun`, increment `err_count`, ignore the window. The current frame continues.
- `frame_err` and `overrun` in the same cycle: both pulse, and `err_count` increments by 2, saturating.
- `err_count` saturates at 2^ERR_W−1. It clears only on reset.
- `busy` = (state != IDLE).

## Timing
- Reset values: `data_out` = 0, `data_valid` = 0, `frame_err` = 0, `overrun` = 0, `err_count` = 0, `busy` = 0, state = IDLE, `flag_d` = 0.
- Reset mid-operation aborts the frame immediately. No partial output.
- Let E be the edge that sees `fall`. Cells are voted on edges E+1..E+10. CHECK runs on edge E+11.
- `data_valid` and `frame_err` are visible after edge E+11, a latency of 11 cycles.
- With `data_ready` held high, `data_valid` is high for exactly one cycle and the block is back in IDLE after E+12.
- Minimum spacing between windows is ≥80 cycles, so overrun occurs only under back-pressure.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `rx_pkg`: `WIN_W` = 80, `SAMPLES_PER_BIT`, `NUM_CELLS`, `VOTE_THRESH` = 5, and the FSM state enum (2-bit encoding).
- One sub-module, `bit_cell_vote`: combinational popcount of an 8-bit cell compared to `VOTE_THRESH`. Instantiated once and fed by a mux on `cell_idx`.

## Test plan
- Clean 0xA5 frame (all 8 samples per cell ideal, parity 0), `data_ready` = 1 → `data_out` = 0xA5 and `data_valid` high for 1 cycle at E+11; `frame_err` = 0; `err_count` = 0.
- 0xA5 with 3 of 8 samples inverted in every cell → still 0xA5. With 4 samples inverted in the data-MSB cell → parity fail: `frame_err` pulse, `err_count` = 1, no `data_valid`.
- 0x3C sent with parity bit 1, or with the start cell all zeros → `frame_err` 1-cycle pulse at E+11 for each case; `err_count` reaches 2.
- Back-pressure: 0x11 accepted into OUTPUT with `data_ready` = 0, then a second window ends → `overrun` pulse, `err_count` +1, `data_out` stays 0x11. Raising `data_ready` → handshake completes; next window decodes normally.
- 260 bad-parity frames → `err_count` = 255 and holds.
- `rst` asserted at E+5 → all outputs 0 immediately. `sample_flag` high at release → no capture. Following 0x7E frame → 0x7E at E'+11.

Source files
------------

// File: rtl/rx_pkg.sv
// rx_pkg: window geometry, vote threshold and FSM encoding shared by the frame decoder
package rx_pkg;
   localparam int WIN_W = 80;
   localparam int SAMPLES_PER_BIT = 8;
   localparam int NUM_CELLS = 10;
   localparam int VOTE_THRESH = 5;
   typedef enum logic [1:0] {IDLE, DECODE, CHECK, OUTPUT} state_t;
endpackage

// File: rtl/bit_cell_vote.sv
// bit_cell_vote: majority vote of one bit cell's samples
module bit_cell_vote
   import rx_pkg::*;
#(
   parameter int W = SAMPLES_PER_BIT
) (
   input  logic [W-1:0] cell_i,
   output logic         bit_o
);
   assign bit_o = $countones(cell_i) >= VOTE_THRESH;
endmodule

// File: rtl/frame_decoder.sv
// frame_decoder: latches each sampler window, votes its bit cells, checks framing
// and presents the byte on a valid/ready handshake with saturating error counting
module frame_decoder #(
   parameter int SAMPLES_PER_BIT = rx_pkg::SAMPLES_PER_BIT,
   parameter int NUM_CELLS       = rx_pkg::NUM_CELLS,
   parameter int ERR_W           = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [rx_pkg::WIN_W-1:0] sample,
   input  logic                    sample_flag,
   output logic [NUM_CELLS-3:0]    data_out,
   output logic                    data_valid,
   input  logic                    data_ready,
   output logic                    frame_err,
   output logic                    overrun,
   output logic [ERR_W-1:0]        err_count,
   output logic                    busy
);
   import rx_pkg::*;
   localparam int CIDX_W = $clog2(NUM_CELLS);
   localparam int BASE_W = $clog2(WIN_W);
   localparam logic [WIN_W-1:0] WIN_MASK = {1'b0, {(WIN_W-1){1'b1}}};
   state_t                state_q, state_d;
   logic                  flag_q;
   logic [WIN_W-1:0]      win_q, win_d;
   logic [CIDX_W-1:0]     cell_idx_q, cell_idx_d;
   logic [NUM_CELLS-1:0]  bits_q, bits_d;
   logic [NUM_CELLS-3:0]  data_out_q, data_out_d;
   logic                  data_valid_q, data_valid_d;
   logic                  frame_err_q, frame_err_d;
   logic                  overrun_q, overrun_d;
   logic [ERR_W-1:0]      err_count_q, err_count_d;
   logic [ERR_W:0]        err_sum;
   logic [BASE_W-1:0]     base;
   logic                  fall, vote, last, ok;
   assign fall = flag_q & ~sample_flag;
   assign base = BASE_W'(WIN_W - 1 - SAMPLES_PER_BIT * int'(cell_idx_q));
   assign last = cell_idx_q == CIDX_W'(NUM_CELLS - 1);
   // start bit must be 1; data plus parity bit must have even weight
   assign ok   = bits_q[NUM_CELLS-1] && !(^bits_q[NUM_CELLS-2:0]);
   bit_cell_vote #(.W(SAMPLES_PER_BIT)) u_vote (
      .cell_i (win_q[base -: SAMPLES_PER_BIT]),
      .bit_o  (vote)
   );
   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      cell_idx_d   = cell_idx_q;
      bits_d       = bits_q;
      data_out_d   = data_out_q;
      data_valid_d = data_valid_q;
      frame_err_d  = 1'b0;
      overrun_d    = fall && (state_q != IDLE);
      case (state_q)
         IDLE: if (fall) begin
            win_d      = sample & WIN_MASK;
            cell_idx_d = '0;
            state_d    = DECODE;
         end
         DECODE: begin
            bits_d     = {bits_q[NUM_CELLS-2:0], vote};
            cell_idx_d = last ? '0 : cell_idx_q + CIDX_W'(1);
            state_d    = last ? CHECK : DECODE;
         end
         CHECK: if (ok) begin
            data_out_d   = bits_q[NUM_CELLS-2:1];
            data_valid_d = 1'b1;
            state_d      = OUTPUT;
         end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
         end
         OUTPUT: if (data_ready) begin
            data_valid_d = 1'b0;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // both error sources may fire together; one extra bit catches saturation
      err_sum     = {1'b0, err_count_q} + (ERR_W+1)'(frame_err_d) + (ERR_W+1)'(overrun_d);
      err_count_d = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         flag_q       <= 1'b0;
         win_q        <= '0;
         cell_idx_q   <= '0;
         bits_q       <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         flag_q       <= sample_flag;
         win_q        <= win_d;
         cell_idx_q   <= cell_idx_d;
         bits_q       <= bits_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         err_count_q  <= err_count_d;
      end
   end
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign frame_err  = frame_err_q;
   assign overrun    = overrun_q;
   assign err_count  = err_count_q;
   assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_frame_decoder.sv
// tb_frame_decoder: directed vector table plus hand-written back-pressure, overlap,
// saturation and reset sequences for frame_decoder
module tb_frame_decoder;
   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       start;
      logic [7:0] inv;
      logic [7:0] inv1;
      logic [7:0] exp_data;
      logic       exp_ferr;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst;
   logic [79:0] sample;
   logic        sample_flag;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        data_ready;
   logic        frame_err;
   logic        overrun;
   logic [7:0]  err_count;
   logic        busy;
   int          errors = 0;
   int          checks = 0;
   int          exp_err = 0;
   logic [7:0]  exp_dout = 8'h00;
   vec_t        vecs [10];
   frame_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .sample      (sample),
      .sample_flag (sample_flag),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .data_ready  (data_ready),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .err_count   (err_count),
      .busy        (busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction
   function automatic vec_t mkv(input logic [7:0] d, input logic p, input logic s,
                                input logic [7:0] inv, input logic [7:0] inv1,
                                input logic [7:0] ed, input logic ef);
      vec_t v;
      v.data = d; v.par = p; v.start = s; v.inv = inv; v.inv1 = inv1;
      v.exp_data = ed; v.exp_ferr = ef;
      return v;
   endfunction
   // cell k occupies w[79-8k -: 8]; every cell gets inv, the data-MSB cell also inv1
   function automatic logic [79:0] mk_window(input vec_t v);
      logic [9:0]  c;
      logic [79:0] w;
      c = {v.start, v.data, v.par};
      w = '0;
      for (int k = 0; k < 10; k++)
         w[79-8*k -: 8] = {8{c[9-k]}} ^ v.inv ^ ((k == 1) ? v.inv1 : 8'h00);
      return w;
   endfunction
   // returns just after edge E, the edge that sees the falling flag
   task automatic send_window(input logic [79:0] w);
      sample = w;
      sample_flag = 1'b1;
      tick();
      tick();
      sample_flag = 1'b0;
      tick();
   endtask
   task automatic run_vec(input vec_t v, input string tag);
      send_window(mk_window(v));
      repeat (10) tick();
      chk({tag, "_valid_e10"}, data_valid, 0);
      tick();
      if (!v.exp_ferr) exp_dout = v.exp_data;
      exp_err = sat(exp_err + (v.exp_ferr ? 1 : 0));
      chk({tag, "_valid_e11"}, data_valid, !v.exp_ferr);
      chk({tag, "_ferr_e11"}, frame_err, v.exp_ferr);
      chk({tag, "_dout_e11"}, data_out, exp_dout);
      chk({tag, "_errcnt_e11"}, err_count, exp_err);
      tick();
      chk({tag, "_valid_e12"}, data_valid, 0);
      chk({tag, "_ferr_e12"}, frame_err, 0);
      chk({tag, "_busy_e12"}, busy, 0);
   endtask
   initial begin
      vecs[0] = mkv(8'hA5, 1'b0, 1'b1, 8'h00, 8'h00, 8'hA5, 1'b0);
      vecs[1] = mkv(8'hA5, 1'b0, 1'b1, 8'h83, 8'h00, 8'hA5, 1'b0);
      vecs[2] = mkv(8'hA5, 1'b0, 1'b1, 8'h00, 8'h0F, 8'h00, 1'b1);
      vecs[3] = mkv(8'h3C, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b1);
      vecs[4] = mkv(8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
      vecs[5] = mkv(8'h3C, 1'b0, 1'b1, 8'h00, 8'h00, 8'h3C, 1'b0);
      vecs[6] = mkv(8'hA5, 1'b0, 1'b1, 8'h07, 8'h00, 8'h00, 1'b1);
      vecs[7] = mkv(8'h01, 1'b1, 1'b1, 8'h00, 8'h00, 8'h01, 1'b0);
      vecs[8] = mkv(8'hFF, 1'b0, 1'b1, 8'h83, 8'h00, 8'hFF, 1'b0);
      vecs[9] = mkv(8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0);
      rst = 1'b1;
      sample = '0;
      sample_flag = 1'b0;
      data_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_dout", data_out, 0);
      chk("rst_valid", data_valid, 0);
      chk("rst_ferr", frame_err, 0);
      chk("rst_ovr", overrun, 0);
      chk("rst_errcnt", err_count, 0);
      chk("rst_busy", busy, 0);
      repeat (3) tick();
      chk("idle_after_rst_busy", busy, 0);
      for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
      // back-pressure: byte parked in OUTPUT while a second window ends
      data_ready = 1'b0;
      send_window(mk_window(mkv(8'h11, 1'b0, 1'b1, 8'h00, 8'h00, 8'h11, 1'b0)));
      repeat (11) tick();
      exp_dout = 8'h11;
      chk("bp_valid", data_valid, 1);
      chk("bp_dout", data_out, 8'h11);
      repeat (5) tick();
      chk("bp_hold_valid", data_valid, 1);
      chk("bp_hold_busy", busy, 1);
      send_window(mk_window(vecs[0]));
      exp_err = sat(exp_err + 1);
      chk("bp_ovr", overrun, 1);
      chk("bp_ovr_errcnt", err_count, exp_err);
      chk("bp_ovr_dout", data_out, 8'h11);
      chk("bp_ovr_valid", data_valid, 1);
      tick();
      chk("bp_ovr_pulse", overrun, 0);
      data_ready = 1'b1;
      tick();
      chk("bp_accept_valid", data_valid, 0);
      chk("bp_accept_busy", busy, 0);
      run_vec(vecs[0], "post_bp");
      // window ending on the CHECK edge of a bad frame: both pulses, count +2
      send_window(mk_window(vecs[3]));
      repeat (8) tick();
      send_window(mk_window(vecs[5]));
      exp_err = sat(exp_err + 2);
      chk("dbl_ferr", frame_err, 1);
      chk("dbl_ovr", overrun, 1);
      chk("dbl_errcnt", err_count, exp_err);
      chk("dbl_valid", data_valid, 0);
      tick();
      chk("dbl_ovr_pulse", overrun, 0);
      chk("dbl_busy", busy, 0);
      for (int i = 0; i < 260; i++) begin
         send_window(mk_window(vecs[3]));
         repeat (11) tick();
         exp_err = sat(exp_err + 1);
         chk("sat_errcnt", err_count, exp_err);
         tick();
      end
      chk("sat_final", err_count, 255);
      chk("sat_dout", data_out, exp_dout);
      // asynchronous reset in the middle of a frame, released with flag still high
      send_window(mk_window(mkv(8'h7E, 1'b0, 1'b1, 8'h00, 8'h00, 8'h7E, 1'b0)));
      repeat (5) tick();
      sample_flag = 1'b1;
      rst = 1'b1;
      #1;
      chk("mid_rst_dout", data_out, 0);
      chk("mid_rst_valid", data_valid, 0);
      chk("mid_rst_ferr", frame_err, 0);
      chk("mid_rst_ovr", overrun, 0);
      chk("mid_rst_errcnt", err_count, 0);
      chk("mid_rst_busy", busy, 0);
      exp_err = 0;
      exp_dout = 8'h00;
      tick();
      rst = 1'b0;
      tick();
      tick();
      chk("rel_flag_high_busy", busy, 0);
      run_vec(mkv(8'h7E, 1'b0, 1'b1, 8'h00, 8'h00, 8'h7E, 1'b0), "post_rst");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
